// File: rtl/exe_muldiv_if.sv
// Request/result bundle between the EXE stage and the multiply/divide unit.
// start is sampled only while busy=0 and is dropped otherwise; results are valid the cycle done=1.
interface exe_muldiv_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [1:0]  state_dbg;

  modport master (
    output start, op, src_a, src_b, flush,
    input  hi, lo, busy, done, div_by_zero, state_dbg
  );

  modport slave (
    input  start, op, src_a, src_b, flush,
    output hi, lo, busy, done, div_by_zero, state_dbg
  );
endinterface

// File: rtl/exe_muldiv.sv
// Iterative 32x32 multiply / 32/32 divide unit: one bit per cycle on magnitudes,
// with sign correction in a final FIX cycle. op: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
module exe_muldiv (
  input  logic         clk,
  input  logic         rst,
  exe_muldiv_if.slave  bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_t;

  state_t      state, state_nxt;
  logic [1:0]  op_q;
  logic        a_neg_q, b_neg_q, dz_q;
  logic [31:0] b_q;
  logic [63:0] acc;
  logic [5:0]  cnt;
  logic [31:0] hi_q, lo_q;
  logic        done_q, dbz_q;
  logic        accept, step, fix_wr, dz_wr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    step      = 1'b0;
    fix_wr    = 1'b0;
    dz_wr     = 1'b0;
    case (state)
      IDLE: if (bus.start && !bus.flush) begin
        accept    = 1'b1;
        state_nxt = CALC;
      end
      CALC: begin
        if (bus.flush) begin
          state_nxt = IDLE;
        end else if (dz_q) begin
          dz_wr     = 1'b1;
          state_nxt = IDLE;
        end else begin
          step = 1'b1;
          if (cnt == 6'd31) state_nxt = FIX;
        end
      end
      FIX: begin
        state_nxt = IDLE;
        fix_wr    = !bus.flush;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Magnitudes are taken only for the signed ops; raw src_a is kept for divide-by-zero.
  logic        a_neg, b_neg, b_zero;
  logic [31:0] a_abs, b_abs;
  assign a_neg  = bus.op[0] & bus.src_a[31];
  assign b_neg  = bus.op[0] & bus.src_b[31];
  assign a_abs  = a_neg ? -bus.src_a : bus.src_a;
  assign b_abs  = b_neg ? -bus.src_b : bus.src_b;
  assign b_zero = bus.op[1] && (bus.src_b == 32'd0);

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
  logic [32:0] mul_sum, div_sh, div_rem;
  logic        div_ge;
  logic [63:0] mul_next, div_next;
  assign mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, b_q} : 33'd0);
  assign mul_next = {mul_sum, acc[31:1]};
  assign div_sh   = {acc[63:32], acc[31]};
  assign div_ge   = div_sh >= {1'b0, b_q};
  assign div_rem  = div_ge ? div_sh - {1'b0, b_q} : div_sh;
  assign div_next = {div_rem[31:0], acc[30:0], div_ge};

  logic        res_neg;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix, res_hi, res_lo;
  assign res_neg  = op_q[0] & (a_neg_q ^ b_neg_q);
  assign prod_fix = res_neg ? -acc : acc;
  assign quo_fix  = res_neg ? -acc[31:0] : acc[31:0];
  assign rem_fix  = (op_q[0] & a_neg_q) ? -acc[63:32] : acc[63:32];
  assign res_hi   = op_q[1] ? rem_fix : prod_fix[63:32];
  assign res_lo   = op_q[1] ? quo_fix : prod_fix[31:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q    <= 2'd0;
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
      dz_q    <= 1'b0;
      b_q     <= 32'd0;
      acc     <= 64'd0;
      cnt     <= 6'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      done_q <= fix_wr | dz_wr;
      if (accept) begin
        op_q    <= bus.op;
        a_neg_q <= a_neg;
        b_neg_q <= b_neg;
        dz_q    <= b_zero;
        b_q     <= b_abs;
        acc     <= {32'd0, b_zero ? bus.src_a : a_abs};
        cnt     <= 6'd0;
        dbz_q   <= 1'b0;
      end
      if (step) begin
        acc <= op_q[1] ? div_next : mul_next;
        cnt <= cnt + 6'd1;
      end
      if (fix_wr) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end
      if (dz_wr) begin
        hi_q  <= acc[31:0];
        lo_q  <= 32'hFFFF_FFFF;
        dbz_q <= 1'b1;
      end
    end
  end

  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.busy        = (state != IDLE);
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.state_dbg   = state;
endmodule

// File: tb/tb_exe_muldiv.sv
// Directed bench for exe_muldiv: vector table for results/latency, then hand
// sequences for flush, ignored start, reset mid-operation and back-to-back issue.
module tb_exe_muldiv;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  exe_muldiv_if bus();
  exe_muldiv dut (.clk(clk), .rst(rst), .bus(bus));

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q[$];
  logic [31:0] last_hi, last_lo;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          lat;
  } vec_t;
  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive a request now, let the next edge accept it, then scramble the operands.
  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.op = op; bus.src_a = a; bus.src_b = b; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.src_a = $urandom;
    bus.src_b = $urandom;
    bus.op    = 2'($urandom_range(0, 3));
  endtask

  task automatic wait_done(input int max, output int lat, output logic busy_ok);
    lat = -1;
    busy_ok = 1'b1;
    for (int i = 1; i <= max; i++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        lat = i;
        break;
      end
      if (!bus.busy) busy_ok = 1'b0;
    end
  endtask

  task automatic watch_no_done(input int n, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (bus.done) seen = 1'b1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic bok, seen;
    logic [63:0] exp;

    vecs[0]  = '{2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33};
    vecs[1]  = '{2'd1, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33};
    vecs[2]  = '{2'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33};
    vecs[3]  = '{2'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33};
    vecs[4]  = '{2'd2, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0, 33};
    vecs[5]  = '{2'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 33};
    vecs[6]  = '{2'd3, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 33};
    vecs[7]  = '{2'd2, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF, 1'b1, 1};
    vecs[8]  = '{2'd1, 32'h00000005, 32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFE2, 1'b0, 33};
    vecs[9]  = '{2'd3, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h0000000E, 1'b0, 33};
    vecs[10] = '{2'd0, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0, 33};

    // Reset state
    rst = 1'b0;
    bus.start = 1'b0; bus.flush = 1'b0; bus.op = 2'd0; bus.src_a = '0; bus.src_b = '0;
    #12;
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    check("reset_hilo", {bus.hi, bus.lo}, 64'd0);
    check("reset_dbz", 64'(bus.div_by_zero), 64'd0);
    check("reset_state", 64'(bus.state_dbg), 64'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) begin
      exp_q.push_back({vecs[i].hi, vecs[i].lo});
      start_op(vecs[i].op, vecs[i].a, vecs[i].b);
      check("dbz_clear_e0", 64'(bus.div_by_zero), 64'd0);
      wait_done(40, lat, bok);
      exp = exp_q.pop_front();
      check("latency", 64'(lat), 64'(vecs[i].lat));
      check("busy_hold", 64'(bok), 64'd1);
      check("busy_at_done", 64'(bus.busy), 64'd0);
      check("hilo", {bus.hi, bus.lo}, exp);
      check("dbz", 64'(bus.div_by_zero), 64'(vecs[i].dbz));
      last_hi = vecs[i].hi; last_lo = vecs[i].lo;
      @(posedge clk); #1;
      check("done_single", 64'(bus.done), 64'd0);
    end

    // Flush 10 cycles into MULTU 5*6
    start_op(2'd0, 32'd5, 32'd6);
    repeat (9) begin @(posedge clk); #1; end
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("flush_busy", 64'(bus.busy), 64'd0);
    check("flush_done", 64'(bus.done), 64'd0);
    watch_no_done(40, seen);
    check("flush_no_done", 64'(seen), 64'd0);
    check("flush_hilo", {bus.hi, bus.lo}, {last_hi, last_lo});

    // start pulsed while busy is dropped
    start_op(2'd0, 32'd2, 32'd3);
    repeat (5) begin @(posedge clk); #1; end
    bus.op = 2'd0; bus.src_a = 32'd7; bus.src_b = 32'd7; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(40, lat, bok);
    check("busy_start_lat", 64'(lat), 64'd27);
    check("busy_start_hilo", {bus.hi, bus.lo}, {32'd0, 32'd6});
    watch_no_done(40, seen);
    check("busy_start_no_queue", 64'(seen), 64'd0);
    last_hi = 32'd0; last_lo = 32'd6;

    // flush and start together in IDLE
    bus.op = 2'd0; bus.src_a = 32'd1; bus.src_b = 32'd1; bus.start = 1'b1; bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.flush = 1'b0;
    check("flush_start_idle", 64'(bus.busy), 64'd0);

    // flush in the FIX cycle
    start_op(2'd0, 32'd9, 32'd9);
    repeat (32) begin @(posedge clk); #1; end
    check("fix_state", 64'(bus.state_dbg), 64'd2);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("fix_flush_done", 64'(bus.done), 64'd0);
    check("fix_flush_busy", 64'(bus.busy), 64'd0);
    check("fix_flush_hilo", {bus.hi, bus.lo}, {last_hi, last_lo});

    // Reset between edges mid-CALC
    start_op(2'd0, 32'd3, 32'd5);
    repeat (10) begin @(posedge clk); #1; end
    #3 rst = 1'b0;
    #1;
    check("async_rst_busy", 64'(bus.busy), 64'd0);
    check("async_rst_done", 64'(bus.done), 64'd0);
    check("async_rst_hilo", {bus.hi, bus.lo}, 64'd0);
    check("async_rst_dbz", 64'(bus.div_by_zero), 64'd0);
    @(negedge clk); rst = 1'b1;
    start_op(2'd0, 32'd3, 32'd4);
    wait_done(40, lat, bok);
    check("post_rst_lat", 64'(lat), 64'd33);
    check("post_rst_hilo", {bus.hi, bus.lo}, {32'd0, 32'd12});

    // Back-to-back: start in the done cycle
    start_op(2'd2, 32'd100, 32'd7);
    check("b2b_done_low", 64'(bus.done), 64'd0);
    check("b2b_busy", 64'(bus.busy), 64'd1);
    wait_done(40, lat, bok);
    check("b2b_lat", 64'(lat), 64'd33);
    check("b2b_hilo", {bus.hi, bus.lo}, {32'd2, 32'd14});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/exe_muldiv.md
EXE_MULDIV -- requirements
Module: exe_muldiv

Interface
REQ-001 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-003 SHALL have port start  in  1  request to begin an operation; sampled only in IDLE.
REQ-004 SHALL have port op  in  2  operation select: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-005 SHALL have port src_a  in  32  multiplicand or dividend, driven from the EXE-stage reg_data1.
REQ-006 SHALL have port src_b  in  32  multiplier or divisor, driven from the EXE-stage reg_data2.
REQ-007 SHALL have port flush  in  1  abort any in-flight operation.
REQ-008 SHALL have port hi  out  32  HI register: upper product or remainder.
REQ-009 SHALL have port lo  out  32  LO register: lower product or quotient.
REQ-010 SHALL have port busy  out  1  high while an operation is in flight; the pipeline stalls on it.
REQ-011 SHALL have port done  out  1  one-cycle pulse when hi/lo are updated.
REQ-012 SHALL have port div_by_zero  out  1  sticky flag; set by a divide with src_b==0.

Function
REQ-013 SHALL implement states IDLE, CALC, FIX; busy = (state != IDLE).
REQ-014 At the accepting edge E0, an IDLE cycle with start=1 and flush=0 SHALL latch op, |src_a| and |src_b|, plus the sign bits.
- Absolute values apply only for signed ops.
- E0 clears div_by_zero and enters CALC with a 6-bit counter at 0.
REQ-015 Operand changes after E0 SHALL have no effect on the result.
REQ-016 CALC SHALL run exactly 32 iterations, edges E1..E32, one bit per edge.
- Multiply: radix-2 shift-add into a 64-bit accumulator.
- Divide: restoring shift-subtract.
- After E32 the state is FIX.
REQ-017 At edge E33, FIX SHALL apply the sign correction, write hi/lo, pulse done for one cycle, and return to IDLE.
- Total latency is 33 edges from the accepting edge to visible results.
REQ-018 Sign rules SHALL be as follows:
- MULT product negated when a[31]^b[31].
- DIV quotient negated when a[31]^b[31].
- DIV remainder takes the sign of a[31].
- Unsigned ops are never corrected.
REQ-019 DIV 0x80000000 / 0xFFFFFFFF SHALL yield lo=0x80000000 and hi=0x00000000 (wrap, no trap).
REQ-020 A divide with src_b==0 at E0 SHALL skip CALC/FIX.
- At edge E1: hi=src_a (as latched), lo=0xFFFFFFFF, div_by_zero=1, done pulse, state returns to IDLE.
REQ-021 start while busy SHALL be ignored, with no queuing.
REQ-022 flush=1 in any state SHALL force IDLE at the next edge.
- done stays 0; hi, lo and div_by_zero keep their prior values.
REQ-023 flush and start both high in IDLE SHALL result in no operation (flush wins).
REQ-024 flush in the FIX cycle SHALL suppress that cycle's hi/lo write and done pulse.
REQ-025 done SHALL never be high for two consecutive cycles.
REQ-026 hi/lo SHALL change only at a done edge or at reset.
REQ-027 start=1 in the cycle done is high SHALL be accepted, since the state is IDLE then (back-to-back operations).

Reset
REQ-028 rst=0 SHALL immediately (asynchronously) force IDLE and clear all outputs.
- busy=0, done=0, div_by_zero=0, hi=0, lo=0.
- Internal accumulator and counter cleared.
REQ-029 Reset asserted mid-operation SHALL discard the operation with no done pulse.
- After release, the block SHALL accept start on the first IDLE cycle.

Verification
REQ-030 MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, done exactly 33 edges after the accepting edge, busy high throughout.
REQ-031 MULT 0xFFFFFFFD*0x00000007 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-032 DIV 0xFFFFFFF9 / 0x00000002 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; also cover DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-033 DIVU 0x00000064 / 0 -> at the next edge hi=0x00000064, lo=0xFFFFFFFF, div_by_zero=1, done=1; a following valid start clears div_by_zero.
REQ-034 Flush and start checks:
- MULTU 5*6 with flush 10 cycles after start -> busy low next edge, no done, hi/lo keep the previous result.
- start pulsed while busy -> ignored.
REQ-035 Reset and back-to-back checks:
- rst=0 mid-CALC, between clock edges -> outputs zero without waiting for a clock edge.
- After release, MULTU 3*4 -> lo=12, hi=0.
- A second start in the done cycle -> accepted, with its own 33-cycle latency.
